// File: rtl/sindoku_grid_scan.sv
// sindoku_grid_scan: sweeps a 9x9 puzzle store in row-major order and
// reports filled/blank/invalid counts plus per-row full and row/column
// duplicate flags for the last completed sweep.
// Ports: Clk/Reset (async, active-high); Start/Auto control sweeps;
//   disp_i/disp_j address the store, disp_value returns the cell combinationally;
//   busy/done/cell_* expose scan progress; *_count and row_full/row_dup/col_dup
//   hold the committed results.
module sindoku_grid_scan (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Start,
   input  logic       Auto,
   output logic [4:0] disp_i,
   output logic [4:0] disp_j,
   input  logic [4:0] disp_value,
   output logic       busy,
   output logic       done,
   output logic       cell_valid,
   output logic [3:0] cell_row,
   output logic [3:0] cell_col,
   output logic [4:0] cell_value,
   output logic [6:0] filled_count,
   output logic [6:0] blank_count,
   output logic [6:0] invalid_count,
   output logic [8:0] row_full,
   output logic [8:0] row_dup,
   output logic [8:0] col_dup
);

   typedef enum logic [2:0] {
      IDLE = 3'b001,
      SCAN = 3'b010,
      DONE = 3'b100
   } state_t;

   state_t state, state_nxt;

   // working state for the sweep in progress
   logic [6:0] w_filled, w_blank, w_invalid;
   logic [8:0] w_row_full, w_row_dup, w_col_dup;
   logic [8:0] row_mask;
   logic [8:0] col_mask [9];

   // working state after folding in the cell being sampled this cycle
   logic [6:0] filled_nxt, blank_nxt, invalid_nxt;
   logic [8:0] row_full_nxt, row_dup_nxt, col_dup_nxt;
   logic [8:0] row_base, row_mask_nxt, col_mask_cur, digit_bit;
   logic [3:0] row_idx, col_idx;
   logic       is_blank, is_filled, is_invalid;
   logic       last_cell, enter_scan;

   assign row_idx   = disp_i[3:0];
   assign col_idx   = disp_j[3:0];
   assign last_cell = (disp_i == 5'd8) && (disp_j == 5'd8);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (Start) state_nxt = SCAN;
         SCAN:    if (last_cell) state_nxt = DONE;
         DONE:    state_nxt = (Auto || Start) ? SCAN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Start while busy is ignored because SCAN only exits on the last cell
   assign enter_scan = (state != SCAN) && (state_nxt == SCAN);

   always_comb begin
      is_blank     = (disp_value == 5'd0);
      is_invalid   = (disp_value > 5'd9);
      is_filled    = !is_blank && !is_invalid;
      digit_bit    = is_filled ? (9'd1 << (disp_value[3:0] - 4'd1)) : 9'd0;
      // row mask restarts at column 0 without needing a separate clear cycle
      row_base     = (disp_j == 5'd0) ? 9'd0 : row_mask;
      row_mask_nxt = row_base | digit_bit;
      col_mask_cur = col_mask[col_idx];

      filled_nxt   = w_filled  + {6'd0, is_filled};
      blank_nxt    = w_blank   + {6'd0, is_blank};
      invalid_nxt  = w_invalid + {6'd0, is_invalid};

      row_dup_nxt  = w_row_dup;
      if (|(row_base & digit_bit)) row_dup_nxt[row_idx] = 1'b1;
      col_dup_nxt  = w_col_dup;
      if (|(col_mask_cur & digit_bit)) col_dup_nxt[col_idx] = 1'b1;
      row_full_nxt = w_row_full;
      if ((disp_j == 5'd8) && (row_mask_nxt == 9'h1FF)) row_full_nxt[row_idx] = 1'b1;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state         <= IDLE;
         disp_i        <= 5'd0;
         disp_j        <= 5'd0;
         w_filled      <= 7'd0;
         w_blank       <= 7'd0;
         w_invalid     <= 7'd0;
         w_row_full    <= 9'd0;
         w_row_dup     <= 9'd0;
         w_col_dup     <= 9'd0;
         row_mask      <= 9'd0;
         for (int k = 0; k < 9; k++) col_mask[k] <= 9'd0;
         filled_count  <= 7'd0;
         blank_count   <= 7'd0;
         invalid_count <= 7'd0;
         row_full      <= 9'd0;
         row_dup       <= 9'd0;
         col_dup       <= 9'd0;
      end else begin
         state <= state_nxt;
         if (enter_scan) begin
            disp_i     <= 5'd0;
            disp_j     <= 5'd0;
            w_filled   <= 7'd0;
            w_blank    <= 7'd0;
            w_invalid  <= 7'd0;
            w_row_full <= 9'd0;
            w_row_dup  <= 9'd0;
            w_col_dup  <= 9'd0;
            row_mask   <= 9'd0;
            for (int k = 0; k < 9; k++) col_mask[k] <= 9'd0;
         end else if (state == SCAN) begin
            w_filled          <= filled_nxt;
            w_blank           <= blank_nxt;
            w_invalid         <= invalid_nxt;
            w_row_full        <= row_full_nxt;
            w_row_dup         <= row_dup_nxt;
            w_col_dup         <= col_dup_nxt;
            row_mask          <= row_mask_nxt;
            col_mask[col_idx] <= col_mask_cur | digit_bit;
            if (last_cell) begin
               // commit uses the *_nxt values so cell (8,8) is included
               disp_i        <= 5'd0;
               disp_j        <= 5'd0;
               filled_count  <= filled_nxt;
               blank_count   <= blank_nxt;
               invalid_count <= invalid_nxt;
               row_full      <= row_full_nxt;
               row_dup       <= row_dup_nxt;
               col_dup       <= col_dup_nxt;
            end else if (disp_j == 5'd8) begin
               disp_j <= 5'd0;
               disp_i <= disp_i + 5'd1;
            end else begin
               disp_j <= disp_j + 5'd1;
            end
         end
      end
   end

   assign busy       = (state == SCAN);
   assign done       = (state == DONE);
   assign cell_valid = busy;
   assign cell_row   = disp_i[3:0];
   assign cell_col   = disp_j[3:0];
   assign cell_value = disp_value;

endmodule

// File: tb/tb_sindoku_grid_scan.sv
module tb_sindoku_grid_scan;

   logic       Clk = 1'b0;
   logic       Reset, Start, Auto;
   logic [4:0] disp_i, disp_j, disp_value;
   logic       busy, done, cell_valid;
   logic [3:0] cell_row, cell_col;
   logic [4:0] cell_value;
   logic [6:0] filled_count, blank_count, invalid_count;
   logic [8:0] row_full, row_dup, col_dup;

   always #5 Clk = ~Clk;

   sindoku_grid_scan dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Auto(Auto),
      .disp_i(disp_i), .disp_j(disp_j), .disp_value(disp_value),
      .busy(busy), .done(done), .cell_valid(cell_valid),
      .cell_row(cell_row), .cell_col(cell_col), .cell_value(cell_value),
      .filled_count(filled_count), .blank_count(blank_count), .invalid_count(invalid_count),
      .row_full(row_full), .row_dup(row_dup), .col_dup(col_dup)
   );

   typedef struct {
      logic [6:0] filled, blank, invalid;
      logic [8:0] full, rdup, cdup;
   } res_t;

   logic [4:0] grid [0:8][0:8];
   res_t       sb [$];
   int         compared = 0;
   int         mismatched = 0;

   // puzzle store model
   always_comb begin
      disp_value = 5'd0;
      if (disp_i < 5'd9 && disp_j < 5'd9) disp_value = grid[disp_i[3:0]][disp_j[3:0]];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // reference: pairwise duplicate search and per-digit presence for full rows
   function automatic res_t model();
      res_t r;
      r.filled = 0; r.blank = 0; r.invalid = 0;
      r.full = 0; r.rdup = 0; r.cdup = 0;
      for (int i = 0; i < 9; i++)
         for (int j = 0; j < 9; j++) begin
            if (grid[i][j] == 0) r.blank++;
            else if (grid[i][j] <= 9) r.filled++;
            else r.invalid++;
         end
      for (int n = 0; n < 9; n++) begin
         bit all_found = 1;
         for (int a = 0; a < 9; a++)
            for (int b = a + 1; b < 9; b++) begin
               if (grid[n][a] >= 1 && grid[n][a] <= 9 && grid[n][a] == grid[n][b]) r.rdup[n] = 1'b1;
               if (grid[a][n] >= 1 && grid[a][n] <= 9 && grid[a][n] == grid[b][n]) r.cdup[n] = 1'b1;
            end
         for (int d = 1; d <= 9; d++) begin
            bit found = 0;
            for (int j = 0; j < 9; j++) if (grid[n][j] == d) found = 1;
            if (!found) all_found = 0;
         end
         r.full[n] = all_found;
      end
      return r;
   endfunction

   task automatic set_blank();
      for (int i = 0; i < 9; i++) for (int j = 0; j < 9; j++) grid[i][j] = 5'd0;
   endtask

   task automatic set_solved();
      for (int i = 0; i < 9; i++)
         for (int j = 0; j < 9; j++) grid[i][j] = 5'(((i * 3 + i / 3 + j) % 9) + 1);
   endtask

   task automatic pop_compare(input string tag);
      res_t e;
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      check({tag, "_filled"},  filled_count,  e.filled);
      check({tag, "_blank"},   blank_count,   e.blank);
      check({tag, "_invalid"}, invalid_count, e.invalid);
      check({tag, "_row_full"}, row_full, e.full);
      check({tag, "_row_dup"},  row_dup,  e.rdup);
      check({tag, "_col_dup"},  col_dup,  e.cdup);
      check({tag, "_sum81"}, filled_count + blank_count + invalid_count, 32'd81);
   endtask

   // Called at a negedge; runs until done is seen. Optionally pulses Start at
   // cycle start_at to show it is ignored mid-sweep.
   task automatic wait_done(input int start_at, output int n_busy, output int n_cyc,
                            output bit stable, output bit ok);
      logic [47:0] snap;
      snap = {filled_count, blank_count, invalid_count, row_full, row_dup, col_dup};
      n_busy = 0; n_cyc = 0; stable = 1; ok = 0;
      for (int c = 0; c < 300; c++) begin
         @(negedge Clk);
         Start = (n_cyc + 1 == start_at);
         n_cyc++;
         if (busy) n_busy++;
         if (done) begin ok = 1; break; end
         if (snap != {filled_count, blank_count, invalid_count, row_full, row_dup, col_dup}) stable = 0;
      end
      Start = 1'b0;
   endtask

   int nb, nc;
   bit st, ok;

   initial begin
      Reset = 1'b1; Start = 1'b0; Auto = 1'b0;
      set_blank();
      repeat (3) @(negedge Clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_disp", {disp_i, disp_j}, 0);
      check("rst_counts", {filled_count, blank_count, invalid_count}, 0);
      check("rst_flags", {row_full, row_dup, col_dup}, 0);
      Reset = 1'b0;
      repeat (2) @(negedge Clk);
      check("idle_hold", busy, 0);

      // all-zero grid
      sb.push_back(model());
      Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      check("scan_entry_addr", {disp_i, disp_j, cell_valid}, 11'h001);
      @(negedge Clk);
      check("scan_addr_adv", {cell_row, cell_col}, 8'h01);
      check("cell_value_pass", cell_value, 0);
      wait_done(0, nb, nc, st, ok);
      check("zero_done_seen", ok, 1);
      check("zero_busy_cycles", nb + 2, 81);
      check("zero_done_cycle", nc + 2, 82);
      check("zero_stable", st, 1);
      check("done_state_out", {disp_i, disp_j, cell_valid}, 0);
      pop_compare("zero");
      @(negedge Clk);
      check("done_one_cycle", {done, busy}, 0);

      // solved grid
      set_solved();
      sb.push_back(model());
      Start = 1'b1;
      wait_done(0, nb, nc, st, ok);
      check("solved_done_cycle", nc, 82);
      pop_compare("solved");

      // duplicate at (3,5) copying (3,0)
      grid[3][5] = grid[3][0];
      sb.push_back(model());
      Start = 1'b1;
      wait_done(0, nb, nc, st, ok);
      check("dup_ok", ok, 1);
      check("dup_row_dup", row_dup, 9'h008);
      check("dup_col5", col_dup[5], 1);
      check("dup_full3", row_full[3], 0);
      pop_compare("dup");

      // single invalid cell
      set_blank();
      grid[4][4] = 5'd12;
      sb.push_back(model());
      Start = 1'b1;
      wait_done(0, nb, nc, st, ok);
      pop_compare("invalid");

      // Reset at SCAN cycle 40, after loading a non-blank result set
      set_solved();
      sb.push_back(model());
      Start = 1'b1;
      wait_done(0, nb, nc, st, ok);
      pop_compare("pre_abort");
      Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      repeat (39) @(negedge Clk);
      check("abort_busy_before", busy, 1);
      Reset = 1'b1;
      #1;
      check("abort_busy", busy, 0);
      check("abort_disp", {disp_i, disp_j}, 0);
      check("abort_counts", {filled_count, blank_count, invalid_count}, 0);
      check("abort_flags", {row_full, row_dup, col_dup}, 0);
      nb = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge Clk);
         if (done) nb++;
      end
      Reset = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(negedge Clk);
         if (done || busy) nb++;
      end
      check("abort_no_done", nb, 0);
      sb.push_back(model());
      Start = 1'b1;
      wait_done(0, nb, nc, st, ok);
      check("post_abort_cycle", nc, 82);
      check("post_abort_busy", nb, 81);
      pop_compare("post_abort");

      // Auto mode: three back-to-back sweeps with a different grid each time
      set_blank();
      grid[0][0] = 5'd3; grid[0][4] = 5'd3; grid[7][2] = 5'd20;
      sb.push_back(model());
      Auto = 1'b1;
      Start = 1'b1;
      wait_done(0, nb, nc, st, ok);
      check("auto1_cycle", nc, 82);
      check("auto1_stable", st, 1);
      pop_compare("auto1");
      set_solved();
      sb.push_back(model());
      wait_done(30, nb, nc, st, ok);
      check("auto2_cycle", nc, 82);
      check("auto2_busy", nb, 81);
      check("auto2_stable", st, 1);
      pop_compare("auto2");
      set_blank();
      grid[2][6] = 5'd9; grid[5][6] = 5'd9;
      sb.push_back(model());
      wait_done(50, nb, nc, st, ok);
      Auto = 1'b0;
      check("auto3_cycle", nc, 82);
      check("auto3_stable", st, 1);
      pop_compare("auto3");
      @(negedge Clk);
      @(negedge Clk);
      check("auto_off_idle", {busy, done}, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
